// File: rtl/bp_gshare_ckpt.sv
// bp_gshare_ckpt: global-history branch direction predictor with a FIFO of
// per-branch history checkpoints, so several branches can be unresolved.
//
// Lookup is combinational in F, allocation happens in D, and branches
// resolve in order in M.
//
// Ports
//   clk, rst           clock, asynchronous active-low reset
//   lookup_pc_i        hashed fetch PC -> lookup_taken_o, lookup_index_o
//   alloc_valid_i      branch in D: push a checkpoint and shift the
//                      speculative history with alloc_taken_i
//   alloc_ready_o      checkpoint FIFO can accept an alloc this cycle
//   resolve_valid_i    oldest branch resolved; resolve_pc_i, resolve_taken_i,
//                      resolve_pred_i
//   flush_i            discard every unresolved branch
//   mispredict_o       registered one-cycle pulse
//   ghr_spec_o         speculative history
//   ghr_retired_o      committed history
//   inflight_o         checkpoint occupancy
//   err_o              sticky: alloc while full, or resolve while empty
module bp_gshare_ckpt #(
    parameter int PHT_DEPTH  = 7,
    parameter int GHR_WIDTH  = 4,
    parameter int CTR_WIDTH  = 2,
    parameter int INDEX_MODE = 1,
    parameter int CKPT_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PHT_DEPTH-1:0]          lookup_pc_i,
    output logic                          lookup_taken_o,
    output logic [PHT_DEPTH-1:0]          lookup_index_o,
    input  logic                          alloc_valid_i,
    input  logic                          alloc_taken_i,
    output logic                          alloc_ready_o,
    input  logic                          resolve_valid_i,
    input  logic [PHT_DEPTH-1:0]          resolve_pc_i,
    input  logic                          resolve_taken_i,
    input  logic                          resolve_pred_i,
    input  logic                          flush_i,
    output logic                          mispredict_o,
    output logic [GHR_WIDTH-1:0]          ghr_spec_o,
    output logic [GHR_WIDTH-1:0]          ghr_retired_o,
    output logic [$clog2(CKPT_DEPTH):0]   inflight_o,
    output logic                          err_o
);

    localparam int NPHT = 1 << PHT_DEPTH;
    localparam int PW   = $clog2(CKPT_DEPTH);
    localparam int CW   = PW + 1;
    localparam logic [CTR_WIDTH-1:0] CTR_INIT = {1'b0, {(CTR_WIDTH-1){1'b1}}};
    localparam logic [CTR_WIDTH-1:0] CTR_MAX  = {CTR_WIDTH{1'b1}};

    // Concat mode: shifting the PC left by GHR_WIDTH keeps its low bits in
    // the upper index field and leaves room for the history below.
    function automatic logic [PHT_DEPTH-1:0] pht_index(
        input logic [PHT_DEPTH-1:0] pc,
        input logic [GHR_WIDTH-1:0] h
    );
        logic [PHT_DEPTH-1:0] hx;
        logic [PHT_DEPTH-1:0] pcs;
        hx  = PHT_DEPTH'(h);
        pcs = pc << GHR_WIDTH;
        if (INDEX_MODE == 0) return pcs | hx;
        else                 return pc ^ hx;
    endfunction

    logic [CTR_WIDTH-1:0] pht_q [NPHT];
    logic [GHR_WIDTH-1:0] ckpt_q [CKPT_DEPTH];
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [GHR_WIDTH-1:0] ghr_spec_q, ghr_spec_d, ghr_ret_q, ghr_ret_d;
    logic                 mispredict_q, mispredict_d, err_q, err_d;

    logic                 empty, full, res_ok, mispred, push;
    logic [GHR_WIDTH-1:0] ckpt_head, hist_resolved;
    logic [PHT_DEPTH-1:0] lookup_idx, res_idx;
    logic [CTR_WIDTH-1:0] ctr_old, ctr_new;

    assign empty         = (cnt_q == '0);
    assign full          = (cnt_q == CW'(CKPT_DEPTH));
    assign res_ok        = resolve_valid_i & ~empty;
    assign mispred       = res_ok & (resolve_taken_i != resolve_pred_i);
    assign ckpt_head     = ckpt_q[rd_ptr_q];
    assign hist_resolved = {ckpt_head[GHR_WIDTH-2:0], resolve_taken_i};
    // A correct resolve frees a slot in the same cycle, so alloc is legal when full.
    assign alloc_ready_o = ~full | res_ok;

    assign lookup_idx     = pht_index(lookup_pc_i, ghr_spec_q);
    assign lookup_index_o = lookup_idx;
    assign lookup_taken_o = pht_q[lookup_idx][CTR_WIDTH-1];

    assign res_idx = pht_index(resolve_pc_i, ckpt_head);
    assign ctr_old = pht_q[res_idx];

    always_comb begin
        ctr_new = ctr_old;
        if (resolve_taken_i) begin
            if (ctr_old != CTR_MAX) ctr_new = ctr_old + CTR_WIDTH'(1);
        end else begin
            if (ctr_old != '0) ctr_new = ctr_old - CTR_WIDTH'(1);
        end
    end

    // Priority: flush > mispredict > alloc. The resolve commit itself is
    // independent of flush/mispredict.
    always_comb begin
        ghr_spec_d   = ghr_spec_q;
        ghr_ret_d    = ghr_ret_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        cnt_d        = cnt_q;
        mispredict_d = 1'b0;
        err_d        = err_q;
        push         = 1'b0;

        if (res_ok) begin
            ghr_ret_d = hist_resolved;
            rd_ptr_d  = rd_ptr_q + PW'(1);
            cnt_d     = cnt_q - CW'(1);
        end
        if (resolve_valid_i && empty) err_d = 1'b1;

        if (flush_i) begin
            ghr_spec_d = ghr_ret_d;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            cnt_d      = '0;
        end else if (mispred) begin
            ghr_spec_d   = hist_resolved;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            cnt_d        = '0;
            mispredict_d = 1'b1;
        end else if (alloc_valid_i) begin
            if (!alloc_ready_o) begin
                err_d = 1'b1;
            end else begin
                push       = 1'b1;
                wr_ptr_d   = wr_ptr_q + PW'(1);
                cnt_d      = cnt_d + CW'(1);
                ghr_spec_d = {ghr_spec_q[GHR_WIDTH-2:0], alloc_taken_i};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
            ghr_spec_q   <= '0;
            ghr_ret_q    <= '0;
            mispredict_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            ghr_spec_q   <= ghr_spec_d;
            ghr_ret_q    <= ghr_ret_d;
            mispredict_q <= mispredict_d;
            err_q        <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CKPT_DEPTH; i++) ckpt_q[i] <= '0;
        end else if (push) begin
            ckpt_q[wr_ptr_q] <= ghr_spec_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NPHT; i++) pht_q[i] <= CTR_INIT;
        end else if (res_ok) begin
            pht_q[res_idx] <= ctr_new;
        end
    end

    assign mispredict_o  = mispredict_q;
    assign ghr_spec_o    = ghr_spec_q;
    assign ghr_retired_o = ghr_ret_q;
    assign inflight_o    = cnt_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_bp_gshare_ckpt.sv
module tb_bp_gshare_ckpt;

    localparam int P = 7;
    localparam int G = 4;
    localparam int C = 2;
    localparam int D = 4;
    localparam int GMASK = (1 << G) - 1;
    localparam int CMAX  = (1 << C) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [P-1:0] lookup_pc_i = '0;
    logic         lookup_taken_o;
    logic [P-1:0] lookup_index_o;
    logic         alloc_valid_i = 1'b0, alloc_taken_i = 1'b0, alloc_ready_o;
    logic         resolve_valid_i = 1'b0;
    logic [P-1:0] resolve_pc_i = '0;
    logic         resolve_taken_i = 1'b0, resolve_pred_i = 1'b0, flush_i = 1'b0;
    logic         mispredict_o, err_o;
    logic [G-1:0] ghr_spec_o, ghr_retired_o;
    logic [2:0]   inflight_o;

    bp_gshare_ckpt #(.PHT_DEPTH(P), .GHR_WIDTH(G), .CTR_WIDTH(C),
                     .INDEX_MODE(1), .CKPT_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .lookup_pc_i(lookup_pc_i), .lookup_taken_o(lookup_taken_o),
        .lookup_index_o(lookup_index_o),
        .alloc_valid_i(alloc_valid_i), .alloc_taken_i(alloc_taken_i),
        .alloc_ready_o(alloc_ready_o),
        .resolve_valid_i(resolve_valid_i), .resolve_pc_i(resolve_pc_i),
        .resolve_taken_i(resolve_taken_i), .resolve_pred_i(resolve_pred_i),
        .flush_i(flush_i), .mispredict_o(mispredict_o),
        .ghr_spec_o(ghr_spec_o), .ghr_retired_o(ghr_retired_o),
        .inflight_o(inflight_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counters as integers, checkpoint FIFO as a queue.
    int pht [1 << P];
    int m_spec, m_ret, m_inflight_q[$];
    bit m_err, m_mis;

    typedef struct {
        int lt, li, ar, mp, gs, gr, inf, er;
    } exp_t;
    exp_t sb[$];

    task automatic model_reset();
        for (int i = 0; i < (1 << P); i++) pht[i] = (1 << (C - 1)) - 1;
        m_spec = 0; m_ret = 0; m_err = 0; m_mis = 0;
        m_inflight_q.delete();
    endtask

    // Drive one cycle's inputs, queue the expected outputs for this cycle,
    // advance the model, then move to just after the next rising edge.
    task automatic cycle(input bit av, input bit at, input bit rv,
                         input logic [P-1:0] rpc, input bit rt, input bit rp,
                         input bit fl, input logic [P-1:0] lpc);
        exp_t e;
        bit   res_ok, ready, mis;
        int   h, idx, hist;
        alloc_valid_i = av; alloc_taken_i = at; resolve_valid_i = rv;
        resolve_pc_i = rpc; resolve_taken_i = rt; resolve_pred_i = rp;
        flush_i = fl; lookup_pc_i = lpc;

        res_ok = rv && (m_inflight_q.size() > 0);
        ready  = (m_inflight_q.size() < D) || res_ok;
        e.li  = (int'(lpc) ^ m_spec) & ((1 << P) - 1);
        e.lt  = (pht[e.li] >= (1 << (C - 1))) ? 1 : 0;
        e.ar  = ready ? 1 : 0;
        e.mp  = m_mis ? 1 : 0;
        e.gs  = m_spec;
        e.gr  = m_ret;
        e.inf = m_inflight_q.size();
        e.er  = m_err ? 1 : 0;
        sb.push_back(e);

        mis = res_ok && (rt != rp);
        if (rv && !res_ok) m_err = 1;
        hist = 0;
        if (res_ok) begin
            h = m_inflight_q.pop_front();
            idx = int'(rpc) ^ h;
            if (rt) pht[idx] = (pht[idx] < CMAX) ? pht[idx] + 1 : CMAX;
            else    pht[idx] = (pht[idx] > 0) ? pht[idx] - 1 : 0;
            hist = ((h << 1) | int'(rt)) & GMASK;
            m_ret = hist;
        end
        m_mis = 0;
        if (fl) begin
            m_spec = m_ret;
            m_inflight_q.delete();
        end else if (mis) begin
            m_spec = hist;
            m_inflight_q.delete();
            m_mis = 1;
        end else if (av) begin
            if (!ready) m_err = 1;
            else begin
                m_inflight_q.push_back(m_spec);
                m_spec = ((m_spec << 1) | int'(at)) & GMASK;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [P-1:0] lpc);
        cycle(0, 0, 0, '0, 0, 0, 0, lpc);
    endtask

    task automatic alloc(input bit t);
        cycle(1, t, 0, '0, 0, 0, 0, 7'h00);
    endtask

    task automatic do_reset();
        alloc_valid_i = 0; resolve_valid_i = 0; flush_i = 0;
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    // Monitor: compares DUT outputs mid-cycle against queued expectations.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("lookup_taken", int'(lookup_taken_o), e.lt);
            check("lookup_index", int'(lookup_index_o), e.li);
            check("alloc_ready",  int'(alloc_ready_o),  e.ar);
            check("mispredict",   int'(mispredict_o),   e.mp);
            check("ghr_spec",     int'(ghr_spec_o),     e.gs);
            check("ghr_retired",  int'(ghr_retired_o),  e.gr);
            check("inflight",     int'(inflight_o),     e.inf);
            check("err",          int'(err_o),          e.er);
        end
    end

    initial begin
        model_reset();
        #1;
        do_reset();

        // Reset defaults
        check("rst_ghr_spec", int'(ghr_spec_o), 0);
        check("rst_ready", int'(alloc_ready_o), 1);
        idle(7'h2A);
        idle(7'h15);

        // Training at history 0: counter 01 -> 10 -> 11 -> 11
        for (int i = 0; i < 3; i++) begin
            alloc(0);
            cycle(0, 0, 1, 7'h15, 1, 1, 0, 7'h15);
        end
        lookup_pc_i = 7'h15;
        #1;
        check("trained_taken", int'(lookup_taken_o), 1);
        idle(7'h15);

        // Speculative history and alloc while full
        do_reset();
        alloc(1); alloc(1); alloc(0); alloc(1);
        check("spec_1101", int'(ghr_spec_o), 4'b1101);
        check("inflight_full", int'(inflight_o), 4);
        check("ready_full", int'(alloc_ready_o), 0);
        alloc(1);
        check("err_overflow", int'(err_o), 1);
        idle(7'h01);

        // Mispredict recovery
        do_reset();
        alloc(1); alloc(1); alloc(1);
        cycle(0, 0, 1, 7'h10, 0, 1, 0, 7'h10);
        check("mp_pulse", int'(mispredict_o), 1);
        check("mp_spec", int'(ghr_spec_o), 0);
        check("mp_inflight", int'(inflight_o), 0);
        check("mp_retired", int'(ghr_retired_o), 0);
        idle(7'h10);

        // Full + correct resolve + alloc; then mispredict + alloc
        do_reset();
        alloc(1); alloc(1); alloc(1); alloc(1);
        cycle(1, 1, 1, 7'h20, 1, 1, 0, 7'h20);
        check("sim_inflight", int'(inflight_o), 4);
        cycle(1, 1, 1, 7'h20, 0, 1, 0, 7'h20);
        check("sim_mp_err", int'(err_o), 0);
        check("sim_mp_inflight", int'(inflight_o), 0);
        idle(7'h20);

        // Flush with two in flight and retired history 0011
        do_reset();
        alloc(1); alloc(1); alloc(1); alloc(1);
        cycle(0, 0, 1, 7'h30, 1, 1, 0, 7'h30);
        cycle(0, 0, 1, 7'h31, 1, 1, 0, 7'h30);
        check("pre_flush_ret", int'(ghr_retired_o), 4'b0011);
        cycle(0, 0, 0, '0, 0, 0, 1, 7'h30);
        check("flush_spec", int'(ghr_spec_o), 4'b0011);
        check("flush_inflight", int'(inflight_o), 0);
        check("flush_no_mp", int'(mispredict_o), 0);
        idle(7'h30);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            bit av, at, rv, rt, rp, fl;
            logic [P-1:0] rpc, lpc;
            av  = ($urandom_range(0, 99) < 60);
            at  = ($urandom_range(0, 1) == 1);
            rv  = (m_inflight_q.size() > 0) ? ($urandom_range(0, 99) < 50)
                                            : ($urandom_range(0, 99) < 2);
            rt  = ($urandom_range(0, 1) == 1);
            rp  = ($urandom_range(0, 99) < 80) ? rt : !rt;
            fl  = ($urandom_range(0, 99) < 3);
            rpc = P'($urandom_range(0, 7) * 5);
            lpc = P'($urandom_range(0, 127));
            cycle(av, at, rv, rpc, rt, rp, fl, lpc);
        end
        idle(7'h00);

        // Reset asserted in the middle of an alloc cycle
        alloc(1); alloc(1);
        alloc_valid_i = 1; alloc_taken_i = 1;
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_spec", int'(ghr_spec_o), 0);
        check("mid_rst_ret", int'(ghr_retired_o), 0);
        check("mid_rst_inflight", int'(inflight_o), 0);
        check("mid_rst_err", int'(err_o), 0);
        check("mid_rst_mp", int'(mispredict_o), 0);
        check("mid_rst_ready", int'(alloc_ready_o), 1);
        check("mid_rst_taken", int'(lookup_taken_o), 0);
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bp_gshare_ckpt.md
Name: bp_gshare_ckpt

Overview:
- Parametrised global-history direction predictor for the pipelined MIPS core.
- Successor to the fixed concat-indexed global predictor. Adds:
  - selectable concat/XOR (gshare) indexing;
  - configurable saturating-counter width;
  - a FIFO of per-branch history checkpoints, so several unresolved branches can be in flight;
  - recovery on mispredict and on full pipeline flush.
- Lookup is combinational at F. Allocation happens at D. In-order resolution happens at M.

Parameters:
- PHT_DEPTH, 7, log2 of PHT entries.
- GHR_WIDTH, 4, global history bits. Legal range 2..PHT_DEPTH; must be < PHT_DEPTH when INDEX_MODE=0.
- CTR_WIDTH, 2, saturating counter bits (>=2).
- INDEX_MODE, 1, 0 = {pc_low, GHR} concatenation; 1 = pc XOR zero-extended GHR.
- CKPT_DEPTH, 4, max unresolved branches (power of 2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- lookup_pc_i  in  PHT_DEPTH  hashed fetch PC.
- lookup_taken_o  out  1  prediction: MSB of the indexed counter.
- lookup_index_o  out  PHT_DEPTH  PHT index used for lookup.
- alloc_valid_i  in  1  branch in D; push checkpoint and shift speculative GHR.
- alloc_taken_i  in  1  prediction that branch used.
- alloc_ready_o  out  1  checkpoint FIFO not full.
- resolve_valid_i  in  1  oldest in-flight branch resolved at M.
- resolve_pc_i  in  PHT_DEPTH  hashed PC of resolving branch.
- resolve_taken_i  in  1  actual direction.
- resolve_pred_i  in  1  direction that was predicted.
- flush_i  in  1  exception/eret flush; discards all unresolved branches.
- mispredict_o  out  1  registered one-cycle pulse.
- ghr_spec_o  out  GHR_WIDTH  speculative history.
- ghr_retired_o  out  GHR_WIDTH  committed history.
- inflight_o  out  log2(CKPT_DEPTH)+1  checkpoint occupancy.
- err_o  out  1  sticky: alloc while full, or resolve while empty.

Behaviour:
- Reset (rst=0, async):
  - GHRs = 0; FIFO empty; inflight_o = 0; mispredict_o = 0; err_o = 0.
  - Every PHT counter = 2^(CTR_WIDTH-1)-1 (weakly not-taken).
  - alloc_ready_o = 1.
  - Reset asserted mid-operation discards all in-flight state immediately.
- Index:
  - INDEX_MODE=0: idx = {pc[PHT_DEPTH-GHR_WIDTH-1:0], h}.
  - INDEX_MODE=1: idx = pc ^ {0, h}.
- Lookup: combinational. Uses the ghr_spec value at the start of the cycle; no same-cycle alloc bypass.
- Alloc (alloc_valid_i & alloc_ready_o):
  - Push the current ghr_spec into the FIFO.
  - ghr_spec <= {ghr_spec[GHR_WIDTH-2:0], alloc_taken_i}.
  - Alloc while full: ignored, err_o set; upstream must stall on !alloc_ready_o.
- Resolve (resolve_valid_i, FIFO non-empty):
  - Pop oldest checkpoint h.
  - PHT[idx(resolve_pc_i, h)] saturating increment if taken, else decrement. No wrap at 0 or 2^CTR_WIDTH-1.
  - ghr_retired <= {h[GHR_WIDTH-2:0], resolve_taken_i}.
  - Resolve while empty: no PHT/GHR change, err_o set.
- Mispredict (valid resolve with resolve_taken_i != resolve_pred_i):
  - ghr_spec <= {h[GHR_WIDTH-2:0], resolve_taken_i}.
  - FIFO cleared; younger entries are wrong-path.
  - mispredict_o = 1 in the next cycle only.
- flush_i:
  - The same-cycle resolve still commits (PHT and ghr_retired updated).
  - ghr_spec <= new ghr_retired value; FIFO cleared; no mispredict_o pulse.
- Priority in one cycle: flush > mispredict > alloc.
  - An alloc coincident with a mispredict or flush is dropped and is not an error.
  - Alloc and a correct resolve in the same cycle both take effect; occupancy is unchanged. This is legal when full because the pop frees a slot: alloc_ready_o = !full | (resolve_valid_i & !empty).
- Same-cycle read/write of the same PHT entry: lookup returns the old counter value.
- PHT update latency: one cycle.

Test Plan:
- Reset, defaults (CTR_WIDTH=2): lookup any pc -> lookup_taken_o=0, counter 01, alloc_ready_o=1, ghr_spec_o=0.
- Training, INDEX_MODE=1: resolve pc=0x15 taken with a correct prediction 3 times, history 0 each time -> counter 01→10→11→11 (saturates); lookup 0x15 with ghr=0 -> taken=1.
- Speculative history: alloc taken,taken,not-taken,taken -> ghr_spec_o=1101, inflight_o=4, alloc_ready_o=0. A fifth alloc without resolve -> ignored, err_o=1.
- Mispredict recovery: from ghr_spec=0000, alloc ×3 with pred taken. Resolve oldest with pred=1, actual=0 -> next cycle mispredict_o=1, ghr_spec_o=0000, inflight_o=0, ghr_retired_o=0000.
- Simultaneous events: FIFO full + correct resolve + alloc in one cycle -> both accepted, inflight_o stays 4. Mispredict + alloc in one cycle -> alloc dropped, err_o stays 0.
- Flush: with 2 in flight and ghr_retired=0011, flush_i alone -> ghr_spec_o=0011, inflight_o=0, mispredict_o=0. Then assert rst low mid-alloc -> all outputs at reset values the same cycle.
